// File: rtl/klotski_pkg.sv
// -----------------------------------------------------------------------------
// klotski_pkg
// Purpose : shared types and helpers for the sliding-puzzle board checker.
//   state_t : checker FSM states (IDLE, SCAN, COUNT, DONE)
//   clog2   : ceiling log2, used to size tile and counter fields
// -----------------------------------------------------------------------------
package klotski_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int b = 0; b < 31; b++) begin
      if ((1 << b) < v) r = b + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/klotski_if.sv
// -----------------------------------------------------------------------------
// klotski_if
// Purpose : request/result bundle between a board source and klotski_checker.
// Signals :
//   i_start      request to check i_board (sampled only when checker idle)
//   i_abort      cancel a check in progress
//   i_board      CELLS tiles of W bits, cell k at [(CELLS-1-k)*W +: W]
//   o_busy       check in progress
//   o_done       one-cycle pulse when results update
//   o_valid      board is a permutation of 0..CELLS-1
//   o_solvable   board is valid and reachable from the goal position
//   o_inversions inversion count (0 for an invalid board)
//   o_blank_pos  cell index of the blank (0 for an invalid board)
// Modports: master drives requests, slave (the checker) drives results.
// -----------------------------------------------------------------------------
interface klotski_if #(
  parameter int N = 4
);

  localparam int CELLS = N * N;
  localparam int W     = klotski_pkg::clog2(CELLS);
  localparam int PAIRS = CELLS * (CELLS - 1) / 2;
  localparam int IW    = klotski_pkg::clog2(PAIRS + 1);

  logic                 i_start;
  logic                 i_abort;
  logic [CELLS*W-1:0]   i_board;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_valid;
  logic                 o_solvable;
  logic [IW-1:0]        o_inversions;
  logic [W-1:0]         o_blank_pos;

  modport master (
    output i_start, i_abort, i_board,
    input  o_busy, o_done, o_valid, o_solvable, o_inversions, o_blank_pos
  );

  modport slave (
    input  i_start, i_abort, i_board,
    output o_busy, o_done, o_valid, o_solvable, o_inversions, o_blank_pos
  );

endinterface

// File: rtl/klotski_checker.sv
// -----------------------------------------------------------------------------
// klotski_checker
// Purpose : checks an N x N sliding-puzzle board. The board is latched on an
//           accepted start, scanned one cell per cycle for range/duplicate
//           errors and the blank position, then every pair (i,j), i<j, is
//           visited one per cycle to count inversions. Solvability follows
//           from the inversion parity plus, for even N, the blank row.
// Ports   :
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    klotski_if.slave: start/abort/board in, busy/done/results out
// Parameters: N board side length, 2..6.
// -----------------------------------------------------------------------------
module klotski_checker
  import klotski_pkg::*;
#(
  parameter int N = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  klotski_if.slave   bus
);

  localparam int CELLS = N * N;
  localparam int W     = clog2(CELLS);
  localparam int PAIRS = CELLS * (CELLS - 1) / 2;
  localparam int IW    = clog2(PAIRS + 1);

  state_t               r_state;
  logic [CELLS*W-1:0]   r_board;
  logic [CELLS-1:0]     r_seen;
  logic                 r_bad;
  logic [W-1:0]         r_k;
  logic [W-1:0]         r_blank;
  logic [W-1:0]         r_i;
  logic [W-1:0]         r_j;
  logic [IW-1:0]        r_inv;

  logic                 r_busy;
  logic                 r_done;
  logic                 r_valid;
  logic                 r_solvable;
  logic [IW-1:0]        r_inv_out;
  logic [W-1:0]         r_blank_out;

  // Unpack the latched board into addressable cells.
  logic [W-1:0]         w_cells [CELLS];

  for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
    assign w_cells[gi] = r_board[(CELLS-1-gi)*W +: W];
  end

  // Scan-side decode for the current cell r_k.
  logic [W-1:0]  w_scan_val;
  logic          w_in_range;
  logic          w_dup;
  logic          w_bad_now;
  logic          w_scan_last;

  assign w_scan_val  = w_cells[r_k];
  // Compare one bit wider so CELLS = 2**W does not wrap to zero.
  assign w_in_range  = ({1'b0, w_scan_val} < (W+1)'(CELLS));
  assign w_dup       = w_in_range && r_seen[w_scan_val];
  assign w_bad_now   = r_bad | ~w_in_range | w_dup;
  assign w_scan_last = (r_k == W'(CELLS - 1));

  // Count-side decode for the current pair (r_i, r_j).
  logic [W-1:0]  w_ci;
  logic [W-1:0]  w_cj;
  logic          w_inc;
  logic [IW-1:0] w_inv_sum;
  logic          w_pair_last;
  logic          w_row_end;
  logic [W-1:0]  w_blank_row;
  logic          w_parity;

  assign w_ci        = w_cells[r_i];
  assign w_cj        = w_cells[r_j];
  assign w_inc       = (w_ci != '0) && (w_cj != '0) && (w_ci > w_cj);
  assign w_inv_sum   = r_inv + {{(IW-1){1'b0}}, w_inc};
  assign w_row_end   = (r_j == W'(CELLS - 1));
  assign w_pair_last = (r_i == W'(CELLS - 2)) && w_row_end;
  assign w_blank_row = r_blank / W'(N);
  // Only the parity of P matters; (N-1-row) is odd exactly when row is even
  // for even N, so its low bit is ~row[0].
  assign w_parity    = w_inv_sum[0] ^ (((N % 2) == 0) ? ~w_blank_row[0] : 1'b0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_board     <= '0;
      r_seen      <= '0;
      r_bad       <= 1'b0;
      r_k         <= '0;
      r_blank     <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_inv       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
      r_solvable  <= 1'b0;
      r_inv_out   <= '0;
      r_blank_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // Start wins over a simultaneous abort here.
          if (bus.i_start) begin
            r_board <= bus.i_board;
            r_seen  <= '0;
            r_bad   <= 1'b0;
            r_k     <= '0;
            r_blank <= '0;
            r_i     <= '0;
            r_j     <= W'(1);
            r_inv   <= '0;
            r_busy  <= 1'b1;
            r_state <= SCAN;
          end
        end

        SCAN: begin
          if (bus.i_abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            if (w_in_range) r_seen[w_scan_val] <= 1'b1;
            if (w_scan_val == '0) r_blank <= r_k;
            r_bad <= w_bad_now;
            r_k   <= r_k + W'(1);
            if (w_scan_last) begin
              if (w_bad_now) begin
                r_valid     <= 1'b0;
                r_solvable  <= 1'b0;
                r_inv_out   <= '0;
                r_blank_out <= '0;
                r_done      <= 1'b1;
                r_busy      <= 1'b0;
                r_state     <= DONE;
              end else begin
                r_state <= COUNT;
              end
            end
          end
        end

        COUNT: begin
          if (bus.i_abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_inv <= w_inv_sum;
            if (w_pair_last) begin
              r_valid     <= 1'b1;
              r_solvable  <= ~w_parity;
              r_inv_out   <= w_inv_sum;
              r_blank_out <= r_blank;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= DONE;
            end else if (w_row_end) begin
              // Next row of the pair triangle starts just right of the diagonal.
              r_i <= r_i + W'(1);
              r_j <= r_i + W'(2);
            end else begin
              r_j <= r_j + W'(1);
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;
  assign bus.o_valid      = r_valid;
  assign bus.o_solvable   = r_solvable;
  assign bus.o_inversions = r_inv_out;
  assign bus.o_blank_pos  = r_blank_out;

endmodule

// File: tb/tb_klotski_checker.sv
// -----------------------------------------------------------------------------
// tb_klotski_checker
// Scoreboard bench for klotski_checker at N=4 and N=3. Drivers push the
// expected result (including the absolute cycle of the done pulse) when a
// start is issued; per-instance monitors pop and compare on every o_done.
// -----------------------------------------------------------------------------
module tb_klotski_checker;

  typedef struct {
    int valid;
    int solv;
    int inv;
    int blank;
    int cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;

  exp_t q4[$];
  exp_t q3[$];

  klotski_if #(.N(4)) bus4();
  klotski_if #(.N(3)) bus3();

  klotski_checker #(.N(4)) u_dut4 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus4)
  );

  klotski_checker #(.N(3)) u_dut3 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus3)
  );

  // Boards: one hex digit per cell for both sizes (W = 4 for N=3 and N=4).
  localparam logic [63:0] B4_SOLVED   = 64'h123456789ABCDEF0;
  localparam logic [63:0] B4_SWAP     = 64'h123456789ABCDFE0;
  localparam logic [63:0] B4_ROW3     = 64'h123456789AB0DEFC;
  localparam logic [63:0] B4_DUP5     = 64'h123455789ABCDEF0;
  localparam logic [63:0] B4_BLANK0   = 64'h0123456789ABCDEF;
  localparam logic [63:0] B4_REVERSED = 64'hFEDCBA9876543210;
  localparam logic [35:0] B3_SOLVED   = 36'h123456780;
  localparam logic [35:0] B3_NINE     = 36'h123456789;
  localparam logic [35:0] B3_SWAP     = 36'h123456870;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc + 1);
    end
  endtask

  // Monitor, N=4
  always @(negedge clk) begin
    if (!rst && bus4.o_done) begin
      if (q4.size() == 0) begin
        chk("n4_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        $display("[TB] N=4 done cycle=%0d valid=%0d solvable=%0d inv=%0d blank=%0d",
                 cyc + 1, bus4.o_valid, bus4.o_solvable, bus4.o_inversions, bus4.o_blank_pos);
        chk("n4_done_cycle", cyc + 1, e.cyc);
        chk("n4_valid", int'(bus4.o_valid), e.valid);
        chk("n4_solvable", int'(bus4.o_solvable), e.solv);
        chk("n4_inversions", int'(bus4.o_inversions), e.inv);
        chk("n4_blank_pos", int'(bus4.o_blank_pos), e.blank);
        chk("n4_busy_at_done", int'(bus4.o_busy), 0);
      end
    end
  end

  // Monitor, N=3
  always @(negedge clk) begin
    if (!rst && bus3.o_done) begin
      if (q3.size() == 0) begin
        chk("n3_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        $display("[TB] N=3 done cycle=%0d valid=%0d solvable=%0d inv=%0d blank=%0d",
                 cyc + 1, bus3.o_valid, bus3.o_solvable, bus3.o_inversions, bus3.o_blank_pos);
        chk("n3_done_cycle", cyc + 1, e.cyc);
        chk("n3_valid", int'(bus3.o_valid), e.valid);
        chk("n3_solvable", int'(bus3.o_solvable), e.solv);
        chk("n3_inversions", int'(bus3.o_inversions), e.inv);
        chk("n3_blank_pos", int'(bus3.o_blank_pos), e.blank);
      end
    end
  end

  // Drivers: called at a negedge; start is sampled by the next posedge (cycle t).
  task automatic start4(input logic [63:0] b, input logic ab);
    bus4.i_board = b;
    bus4.i_start = 1'b1;
    bus4.i_abort = ab;
    @(negedge clk);
    bus4.i_start = 1'b0;
    bus4.i_abort = 1'b0;
  endtask

  task automatic go4(input logic [63:0] b, input logic ab,
                     input int v, input int s, input int inv, input int bl, input int lat);
    exp_t e;
    e = '{v, s, inv, bl, cyc + 1 + lat};
    q4.push_back(e);
    start4(b, ab);
    chk("n4_busy_after_start", int'(bus4.o_busy), 1);
  endtask

  task automatic go3(input logic [35:0] b,
                     input int v, input int s, input int inv, input int bl, input int lat);
    exp_t e;
    e = '{v, s, inv, bl, cyc + 1 + lat};
    q3.push_back(e);
    bus3.i_board = b;
    bus3.i_start = 1'b1;
    @(negedge clk);
    bus3.i_start = 1'b0;
    chk("n3_busy_after_start", int'(bus3.o_busy), 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && (q4.size() != 0 || q3.size() != 0); i++) @(negedge clk);
    if (q4.size() != 0 || q3.size() != 0) begin
      chk("done_timeout", q4.size() + q3.size(), 0);
      q4.delete();
      q3.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_cleared4(input string nm);
    chk({nm, "_busy"}, int'(bus4.o_busy), 0);
    chk({nm, "_done"}, int'(bus4.o_done), 0);
    chk({nm, "_valid"}, int'(bus4.o_valid), 0);
    chk({nm, "_solvable"}, int'(bus4.o_solvable), 0);
    chk({nm, "_inversions"}, int'(bus4.o_inversions), 0);
    chk({nm, "_blank_pos"}, int'(bus4.o_blank_pos), 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus4.i_start = 1'b0; bus4.i_abort = 1'b0; bus4.i_board = '0;
    bus3.i_start = 1'b0; bus3.i_abort = 1'b0; bus3.i_board = '0;

    repeat (3) @(negedge clk);
    chk_cleared4("reset");
    chk("reset_n3_valid", int'(bus3.o_valid), 0);

    // Start in the very first cycle after reset release.
    rst = 1'b0;
    go4(B4_SOLVED, 1'b0, 1, 1, 0, 15, 137);
    wait_drain();

    go4(B4_SWAP,     1'b0, 1, 0, 1,   15, 137);  wait_drain();
    go4(B4_ROW3,     1'b0, 1, 1, 3,   11, 137);  wait_drain();
    go4(B4_DUP5,     1'b0, 0, 0, 0,   0,  17);   wait_drain();
    // Start with abort in IDLE: start accepted.
    go4(B4_BLANK0,   1'b1, 1, 0, 0,   0,  137);  wait_drain();
    go4(B4_REVERSED, 1'b0, 1, 0, 105, 15, 137);  wait_drain();

    // Board changes after acceptance must not matter.
    go4(B4_SOLVED, 1'b0, 1, 1, 0, 15, 137);
    bus4.i_board = B4_DUP5;
    wait_drain();

    // Abort mid-count, restart, and an ignored start while busy.
    start4(B4_SWAP, 1'b0);
    repeat (49) @(negedge clk);
    bus4.i_abort = 1'b1;
    @(negedge clk);
    bus4.i_abort = 1'b0;
    chk("abort_busy", int'(bus4.o_busy), 0);
    chk("abort_keeps_valid", int'(bus4.o_valid), 1);
    chk("abort_keeps_inversions", int'(bus4.o_inversions), 0);
    @(negedge clk);
    go4(B4_REVERSED, 1'b0, 1, 0, 105, 15, 137);
    repeat (7) @(negedge clk);
    start4(B4_DUP5, 1'b0);
    wait_drain();
    // Abort while idle does nothing; nothing spurious may follow.
    bus4.i_abort = 1'b1;
    @(negedge clk);
    bus4.i_abort = 1'b0;
    repeat (200) @(negedge clk);
    chk("idle_abort_keeps_inversions", int'(bus4.o_inversions), 105);

    // Reset mid-check: no done, results cleared.
    start4(B4_SOLVED, 1'b0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_cleared4("midreset");
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("after_midreset_valid", int'(bus4.o_valid), 0);

    // N=3 instance.
    go3(B3_SOLVED, 1, 1, 0, 8, 46);  wait_drain();
    go3(B3_NINE,   0, 0, 0, 0, 10);  wait_drain();
    go3(B3_SWAP,   1, 0, 1, 8, 46);  wait_drain();

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
